// File: rtl/fib_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fib_sequencer_if
// Description : Instruction and control bundle between the Fibonacci
//               microprogram sequencer and its environment.
//               master : sequencer side (takes start/n_terms, drives the
//                        instruction stream and status)
//               slave  : environment side (drives start/n_terms, observes)
//               Signals: start, n_terms, op_code, Opr1, Opr2, busy, done,
//                        term_cnt
// Revision    : 1.0  initial release
// ============================================================================
interface fib_sequencer_if #(
    parameter int SIZE  = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic [SIZE-2:0]  op_code;
    logic [SIZE-3:0]  Opr1;
    logic [SIZE-3:0]  Opr2;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] term_cnt;

    modport master (
        input  start, n_terms,
        output op_code, Opr1, Opr2, busy, done, term_cnt
    );

    modport slave (
        output start, n_terms,
        input  op_code, Opr1, Opr2, busy, done, term_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fib_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fib_sequencer
// Description : Moore-FSM microprogram sequencer feeding the Fibonacci
//               datapath decoder. On an accepted start it issues
//               CLR, LD_A, LD_B, EMIT0, then {ADD1, MOV, ADD2, EMIT} per
//               further term, then HALT. Counts EMITs against a latched
//               request length.
// Ports       : clk, rst (sync, active-high)
//               stall      - freeze sequencing (only with FIB_SEQ_STALL_EN)
//               bus.master - start, n_terms in; op_code, Opr1, Opr2,
//                            busy, done, term_cnt out
// Config      : `define FIB_SEQ_STALL_EN to add the stall input.
// Revision    : 1.0  initial release
// ============================================================================
module fib_sequencer #(
    parameter int SIZE  = 4,
    parameter int CNT_W = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
`ifdef FIB_SEQ_STALL_EN
    input  wire logic       stall,
`endif
    fib_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLR   = 4'd1,
        S_LD_A  = 4'd2,
        S_LD_B  = 4'd3,
        S_EMIT0 = 4'd4,
        S_ADD1  = 4'd5,
        S_MOV   = 4'd6,
        S_ADD2  = 4'd7,
        S_EMIT  = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [SIZE-2:0] c_OP_NOP  = (SIZE-1)'(3'b000);
    localparam logic [SIZE-2:0] c_OP_LD   = (SIZE-1)'(3'b001);
    localparam logic [SIZE-2:0] c_OP_HALT = (SIZE-1)'(3'b011);
    localparam logic [SIZE-2:0] c_OP_CLR  = (SIZE-1)'(3'b100);
    localparam logic [SIZE-2:0] c_OP_EMIT = (SIZE-1)'(3'b101);
    localparam logic [SIZE-2:0] c_OP_MOV  = (SIZE-1)'(3'b110);
    localparam logic [SIZE-2:0] c_OP_ADD  = (SIZE-1)'(3'b111);

    localparam logic [SIZE-3:0] c_R0 = (SIZE-2)'(2'b00);
    localparam logic [SIZE-3:0] c_R1 = (SIZE-2)'(2'b01);
    localparam logic [SIZE-3:0] c_R2 = (SIZE-2)'(2'b10);
    localparam logic [SIZE-3:0] c_R3 = (SIZE-2)'(2'b11);

    state_t           r_state;
    logic [CNT_W-1:0] r_term_cnt;
    logic [CNT_W-1:0] r_n_len;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hold;

    // A stall only freezes an active run; IDLE keeps accepting start.
`ifdef FIB_SEQ_STALL_EN
    assign w_hold = stall && (r_state != S_IDLE);
`else
    assign w_hold = 1'b0;
`endif

    assign w_cnt_inc = r_term_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_term_cnt <= '0;
            r_n_len    <= '0;
        end else if (!w_hold) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_term_cnt <= '0;
                        if (bus.n_terms != '0) begin
                            r_n_len <= bus.n_terms;
                            r_state <= S_CLR;
                        end else begin
                            r_state <= S_HALT;
                        end
                    end
                end
                S_CLR:  r_state <= S_LD_A;
                S_LD_A: r_state <= S_LD_B;
                S_LD_B: r_state <= S_EMIT0;
                // Decide on the post-increment count so the run stops
                // exactly at n_len and the counter never wraps.
                S_EMIT0, S_EMIT: begin
                    r_term_cnt <= w_cnt_inc;
                    r_state    <= (w_cnt_inc == r_n_len) ? S_HALT : S_ADD1;
                end
                S_ADD1: r_state <= S_MOV;
                S_MOV:  r_state <= S_ADD2;
                S_ADD2: r_state <= S_EMIT;
                S_HALT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Instruction decode from the state register; a stalled cycle shows NOP
    // so the decoder performs no register write.
    always_comb begin
        bus.op_code = c_OP_NOP;
        bus.Opr1    = c_R0;
        bus.Opr2    = c_R0;
        if (!w_hold) begin
            case (r_state)
                S_CLR:   bus.op_code = c_OP_CLR;
                S_LD_A:  begin bus.op_code = c_OP_LD;  bus.Opr1 = c_R1; end
                S_LD_B:  begin bus.op_code = c_OP_LD;  bus.Opr1 = c_R2; end
                S_EMIT0: bus.op_code = c_OP_EMIT;
                S_ADD1:  begin bus.op_code = c_OP_ADD; bus.Opr1 = c_R3; bus.Opr2 = c_R1; end
                S_MOV:   begin bus.op_code = c_OP_MOV; bus.Opr1 = c_R1; bus.Opr2 = c_R2; end
                S_ADD2:  begin bus.op_code = c_OP_ADD; bus.Opr1 = c_R2; bus.Opr2 = c_R3; end
                S_EMIT:  bus.op_code = c_OP_EMIT;
                S_HALT:  bus.op_code = c_OP_HALT;
                default: bus.op_code = c_OP_NOP;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_HALT) && !w_hold;
    assign bus.term_cnt = r_term_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fib_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_sequencer
// Description : Directed self-checking bench for fib_sequencer. Each cycle
//               the bench advances to just after the rising edge, drives
//               inputs, settles, then compares outputs against hand-derived
//               instruction sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fib_sequencer;

    localparam logic [6:0] I_NOP  = 7'b000_00_00;
    localparam logic [6:0] I_CLR  = 7'b100_00_00;
    localparam logic [6:0] I_LDA  = 7'b001_01_00;
    localparam logic [6:0] I_LDB  = 7'b001_10_00;
    localparam logic [6:0] I_EMIT = 7'b101_00_00;
    localparam logic [6:0] I_ADD1 = 7'b111_11_01;
    localparam logic [6:0] I_MOV  = 7'b110_01_10;
    localparam logic [6:0] I_ADD2 = 7'b111_10_11;
    localparam logic [6:0] I_HALT = 7'b011_00_00;

    logic clk = 1'b0;
    logic rst;
`ifdef FIB_SEQ_STALL_EN
    logic stall;
`endif
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fib_sequencer_if #(.SIZE(4), .CNT_W(4)) bus ();

    fib_sequencer #(.SIZE(4), .CNT_W(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
`ifdef FIB_SEQ_STALL_EN
        .stall (stall),
`endif
        .bus   (bus.master)
    );

    logic [6:0] instr;
    assign instr = {bus.op_code, bus.Opr1, bus.Opr2};

    // Expected instruction in cycle c (c=1 is the cycle after start) of a
    // run requesting n terms.
    function automatic logic [6:0] exp_instr(input int n, input int c);
        if (n == 0) return (c == 1) ? I_HALT : I_NOP;
        if (c == 1) return I_CLR;
        if (c == 2) return I_LDA;
        if (c == 3) return I_LDB;
        if (c == 4) return I_EMIT;
        if (c == 4 * n + 1) return I_HALT;
        if (c > 4 * n + 1 || c < 1) return I_NOP;
        case ((c - 4) % 4)
            1: return I_ADD1;
            2: return I_MOV;
            3: return I_ADD2;
            default: return I_EMIT;
        endcase
    endfunction

    task automatic advance;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.n_terms = '0;
`ifdef FIB_SEQ_STALL_EN
        stall = 1'b0;
`endif
        advance(); advance();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            advance(); #1;
            checks++;
            if (instr !== I_NOP || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.term_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_idle c%0d: instr=%b busy=%b done=%b cnt=%0d, want %b 0 0 0",
                         c, instr, bus.busy, bus.done, bus.term_cnt, I_NOP);
            end
        end
    endtask

    // Generic directed run: start at cycle 0, walk through HALT and the
    // first idle cycle. n_terms is scrambled after acceptance.
    task automatic test_run(input int n, input string name);
        int last = (n == 0) ? 1 : 4 * n + 1;
        advance();
        bus.start = 1'b1;
        bus.n_terms = 4'(n);
        for (int c = 1; c <= last + 1; c++) begin
            advance();
            bus.start = 1'b0;
            bus.n_terms = 4'(n + 5);
            #1;
            checks++;
            if (instr !== exp_instr(n, c)) begin
                errors++;
                $display("FAIL %s instr c%0d: got %b want %b", name, c, instr, exp_instr(n, c));
            end
            checks++;
            if (bus.busy !== (c <= last) || bus.done !== (c == last)) begin
                errors++;
                $display("FAIL %s flags c%0d: busy=%b done=%b want %b %b",
                         name, c, bus.busy, bus.done, c <= last, c == last);
            end
            if (c == last || c == last + 1) begin
                checks++;
                if (bus.term_cnt !== 4'(n)) begin
                    errors++;
                    $display("FAIL %s term_cnt c%0d: got %0d want %0d", name, c, bus.term_cnt, n);
                end
            end
        end
    endtask

    task automatic test_restart_and_reset;
        bit saw_done = 0;
        advance();
        bus.start = 1'b1;
        bus.n_terms = 4'd2;
        for (int c = 1; c <= 6; c++) begin
            advance();
            bus.start = (c == 3);
            bus.n_terms = (c == 3) ? 4'd7 : 4'd2;
            rst = (c == 6);
            #1;
            if (bus.done === 1'b1) saw_done = 1;
            checks++;
            if (instr !== exp_instr(2, c) || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL restart_ignored c%0d: instr=%b busy=%b want %b 1",
                         c, instr, bus.busy, exp_instr(2, c));
            end
        end
        for (int c = 7; c <= 8; c++) begin
            advance();
            rst = 1'b0;
            bus.start = 1'b0;
            #1;
            if (bus.done === 1'b1) saw_done = 1;
            checks++;
            if (instr !== I_NOP || bus.busy !== 1'b0 || bus.term_cnt !== 4'd0) begin
                errors++;
                $display("FAIL midrun_reset c%0d: instr=%b busy=%b cnt=%0d want %b 0 0",
                         c, instr, bus.busy, bus.term_cnt, I_NOP);
            end
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done: got done=1 want never");
        end
    endtask

    // start held through HALT must not be accepted until IDLE; rst with
    // start in the same cycle must win.
    task automatic test_boundaries;
        advance();
        bus.start = 1'b1;
        bus.n_terms = 4'd1;
        for (int c = 1; c <= 5; c++) begin
            advance();
            bus.start = (c == 5);
            #1;
        end
        checks++;
        if (instr !== I_HALT || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL halt_cycle: instr=%b done=%b want %b 1", instr, bus.done, I_HALT);
        end
        advance();
        bus.start = 1'b0;
        #1;
        checks++;
        if (instr !== I_NOP || bus.busy !== 1'b0 || bus.term_cnt !== 4'd1) begin
            errors++;
            $display("FAIL start_in_halt: instr=%b busy=%b cnt=%0d want %b 0 1",
                     instr, bus.busy, bus.term_cnt, I_NOP);
        end
        advance();
        bus.start = 1'b1;
        bus.n_terms = 4'd3;
        rst = 1'b1;
        advance();
        bus.start = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (instr !== I_NOP || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_beats_start: instr=%b busy=%b want %b 0", instr, bus.busy, I_NOP);
        end
    endtask

`ifdef FIB_SEQ_STALL_EN
    task automatic test_stall;
        logic [6:0] exp [1:12];
        exp = '{I_CLR, I_LDA, I_LDB, I_EMIT, I_NOP, I_NOP, I_ADD1, I_MOV,
                I_ADD2, I_EMIT, I_HALT, I_NOP};
        advance();
        bus.start = 1'b1;
        bus.n_terms = 4'd2;
        for (int c = 1; c <= 12; c++) begin
            advance();
            bus.start = 1'b0;
            stall = (c == 5 || c == 6);
            #1;
            checks++;
            if (instr !== exp[c] || bus.busy !== (c <= 11) || bus.done !== (c == 11)) begin
                errors++;
                $display("FAIL stall c%0d: instr=%b busy=%b done=%b want %b %b %b",
                         c, instr, bus.busy, bus.done, exp[c], c <= 11, c == 11);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run(3, "run3");
        test_run(0, "run0");
        test_run(1, "run1");
        test_run(15, "run15");
        test_restart_and_reset();
        test_boundaries();
`ifdef FIB_SEQ_STALL_EN
        test_stall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fib_sequencer.md
# fib_sequencer

Microprogram sequencer that drives the Fibonacci datapath instruction decoder. On a `start` pulse it issues a fixed op_code/Opr1/Opr2 stream, one instruction per clock: clear, two seed loads, then one add/move/add/emit loop iteration per Fibonacci term, and finally a halt. It counts emitted terms against a latched request length. It replaces the hand-driven instruction stream in front of the decoder, which then feeds the register file and ALU.

## Interface
- `SIZE`, 4: datapath size code; op_code width SIZE-1, operand width SIZE-2 (decoder convention).
- `CNT_W`, 4: width of term count and request length.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `n_terms`  in  CNT_W  number of terms to emit; latched when `start` is accepted.
- `stall`  in  1  freeze sequencing; present only with `FIB_SEQ_STALL_EN`.
- `op_code`  out  SIZE-1  instruction opcode to decoder.
- `Opr1`, `Opr2`  out  SIZE-2  instruction operands to decoder.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  high for exactly the HALT cycle.
- `term_cnt`  out  CNT_W  number of EMIT instructions issued in the current or last run.

## Operation
- Moore FSM. Outputs are decoded from the state register only. `term_cnt` and latched `n_len` are registers.
- Each state emits op_code/Opr1/Opr2 as follows:
  - IDLE: 000/00/00 (NOP)
  - CLR: 100/00/00
  - LD_A: 001/01/00
  - LD_B: 001/10/00
  - EMIT0: 101/00/00
  - ADD1: 111/11/01
  - MOV: 110/01/10
  - ADD2: 111/10/11
  - EMIT: 101/00/00
  - HALT: 011/00/00
- Transitions:
  - IDLE→CLR on `start` with n_terms≠0. Latch `n_len`=n_terms and clear `term_cnt`.
  - IDLE→HALT on `start` with n_terms=0. Clear `term_cnt`.
  - CLR→LD_A→LD_B→EMIT0 unconditionally.
  - EMIT0 and EMIT each increment `term_cnt`. They then go to HALT if the incremented count equals `n_len`, else to ADD1.
  - ADD1→MOV→ADD2→EMIT.
  - HALT→IDLE.
- `start` is ignored while busy. A `n_terms` change after acceptance has no effect.
- `term_cnt` holds its final value in IDLE until the next accepted `start`.
- `term_cnt` never exceeds `n_len`, so it cannot wrap. Maximum run is 2^CNT_W−1 terms.

## Timing
- Reset: state=IDLE, `term_cnt`=0, `n_len`=0. Outputs are therefore op_code=000, Opr1=Opr2=00, busy=0, done=0.
- `start` high in cycle k: CLR appears on outputs in cycle k+1, with `busy`=1 from k+1.
- Run length for n≥1: 4 + 4·(n−1) + 1 cycles of busy. EMIT0 is in cycle k+4. The m-th EMIT (m≥2) is in cycle k+4+4·(m−1). HALT/`done` is in the cycle after the last EMIT.
- n=0: HALT in cycle k+1 (busy=1, done=1), IDLE in k+2.
- `start` in the HALT cycle is ignored. The earliest new accept is the first IDLE cycle.
- `rst` asserted mid-run: IDLE/NOP from the next cycle. No HALT or `done` is produced.
- `rst` and `start` in the same cycle: reset wins.

## Configuration
- `FIB_SEQ_STALL_EN` defined:
  - `stall` port exists.
  - While `stall`=1 in a non-IDLE state, the state, `term_cnt` and `n_len` hold, and outputs are forced to NOP 000/00/00 so the decoder issues no write. `busy` stays 1; `done` is forced to 0.
  - The held instruction reissues in the first cycle with `stall`=0.
  - `stall` has no effect in IDLE. `start` acceptance is unaffected.
- Undefined: no `stall` port; the sequencer never pauses.

## Test plan
- Reset, then idle 3 cycles → op_code=000, Opr1=Opr2=00, busy=0, done=0, term_cnt=0.
- start with n_terms=3 at cycle 0 → cycles 1–13 produce:
  - 100/00/00, 001/01/00, 001/10/00, 101/00/00
  - then twice: 111/11/01, 110/01/10, 111/10/11, 101/00/00
  - then 011/00/00 with done=1 in cycle 13 only.
  - term_cnt=3 in cycle 14. busy is low from cycle 14.
- start with n_terms=0 → HALT in cycle 1 with done=1, term_cnt=0. start with n_terms=1 → CLR, LD_A, LD_B, EMIT0, HALT in cycles 1–5.
- start with n_terms=2, re-pulse start with n_terms=7 in cycle 3, rst in cycle 6 → run unaffected until reset. Cycle 7 shows NOP, busy=0, term_cnt=0, and done never asserts.
- `FIB_SEQ_STALL_EN`: n_terms=2, stall=1 during cycles 5–6 (ADD1) → NOP on outputs in cycles 5–6. ADD1 appears in cycle 7, and HALT moves from cycle 9 to cycle 11.
